rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter_pkg.sv | 16 +
 rtl/rr_grant_arbiter_one_hot_to_integer.sv | 25 ++
 rtl/rr_grant_arbiter.sv | 115 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types for the round-robin grant arbiter.
// Holds the FSM state enum and the grant index width helper.
package rr_grant_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 32;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_one_hot_to_integer.sv
// One-hot to binary index encoder.
// Output is zero when no bit is set.
module one_hot_to_integer
    import rr_grant_arbiter_pkg::*;
#(
    parameter int C_WIDTH = 4
)
(
    input  logic [C_WIDTH-1:0]              one_hot,
    output logic [id_width(C_WIDTH)-1:0]    index
);

    localparam int IW = id_width(C_WIDTH);

    // OR together the indices of all set bits
    always_comb begin
        index = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (one_hot[i]) begin
                index = index | IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with registered one-hot grant.
// Optional macro RR_GRANT_LOCK_EN adds grant_lock for multi-beat ownership.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              request,
    output logic                            grant_valid,
    output logic [NUM_REQ-1:0]              grant_one_hot,
    output logic [id_width(NUM_REQ)-1:0]    grant_id,
    input  logic                            grant_ack
`ifdef RR_GRANT_LOCK_EN
    ,
    input  logic                            grant_lock
`endif
);

    localparam int IW = id_width(NUM_REQ);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] grant_d;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      ptr_d;
    logic [IW-1:0]      ptr_nxt;
    logic [IW-1:0]      ptr_srch;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] sel;
    logic               lock;

`ifdef RR_GRANT_LOCK_EN
    assign lock = grant_lock;
`else
    assign lock = 1'b0;
`endif

    // Pointer value that follows a release of the current grant
    assign ptr_nxt = (grant_id == IW'(NUM_REQ - 1)) ? '0
                   : grant_id + IW'(1);

    // On a release the acked requester is excluded and the search
    // starts just above it, so re-arbitration needs no idle cycle.
    // A single requester is never masked, allowing back-to-back grants.
    assign cand = (state_q == GRANTED && NUM_REQ > 1)
                ? (request & ~grant_q) : request;

    assign ptr_srch = (state_q == GRANTED) ? ptr_nxt : ptr_q;

    assign mask   = ~((NUM_REQ'(1) << ptr_srch) - NUM_REQ'(1));
    assign masked = cand & mask;
    assign pick   = (masked != '0) ? masked : cand;
    assign sel    = pick & (~pick + NUM_REQ'(1));

    // Next-state, next-grant and pointer update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    state_d = GRANTED;
                    grant_d = sel;
                end
            end
            GRANTED: begin
                if (grant_ack && !lock) begin
                    ptr_d = ptr_nxt;
                    if (sel != '0) begin
                        grant_d = sel;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_valid   = (state_q == GRANTED);
    assign grant_one_hot = grant_q;

    one_hot_to_integer #(
        .C_WIDTH (NUM_REQ)
    ) u_enc (
        .one_hot (grant_q),
        .index   (grant_id)
    );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter (NUM_REQ=4).
// Expected outputs come from a loop-search reference model queued per cycle.
module tb_rr_grant_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request;
    logic       grant_valid;
    logic [3:0] grant_one_hot;
    logic [1:0] grant_id;
    logic       grant_ack;
    logic       lock_i;

    typedef struct packed {
        logic       v;
        logic [3:0] oh;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic m_v = 1'b0;
    int   m_id = 0;
    int   m_ptr = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .grant_valid   (grant_valid),
        .grant_one_hot (grant_one_hot),
        .grant_id      (grant_id),
        .grant_ack     (grant_ack)
`ifdef RR_GRANT_LOCK_EN
        ,
        .grant_lock    (lock_i)
`endif
    );

    function automatic int search(input logic [3:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic r, input logic [3:0] q,
                         input logic a, input logic l);
        exp_t       e;
        int         s;
        logic [3:0] c;
        logic       lk;
        rst       = r;
        request   = q;
        grant_ack = a;
        lock_i    = l;
`ifdef RR_GRANT_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
`endif
        if (r) begin
            m_v = 1'b0;
            m_id = 0;
            m_ptr = 0;
        end else if (!m_v) begin
            s = search(q, m_ptr);
            if (s >= 0) begin
                m_v = 1'b1;
                m_id = s;
            end
        end else if (a && !lk) begin
            m_ptr = (m_id + 1) % N;
            c = q;
            c[m_id] = 1'b0;
            s = search(c, m_ptr);
            if (s >= 0) begin
                m_id = s;
            end else begin
                m_v = 1'b0;
                m_id = 0;
            end
        end
        e.v  = m_v;
        e.oh = m_v ? 4'(1 << m_id) : 4'b0000;
        e.id = 2'(m_id);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1111, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id) begin
                errors++;
                $display("FAIL reset: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
        end
        checks++;
        if (grant_valid !== 1'b0 || grant_one_hot !== 4'b0000 ||
            grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_const: got v=%b oh=%b id=%0d want 0 0 0",
                     grant_valid, grant_one_hot, grant_id);
        end
    endtask

    task automatic test_idle_basic();
        exp_t e;
        logic [3:0] rq [0:3];
        rq = '{4'b0000, 4'b0000, 4'b1010, 4'b1010};
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, rq[i], 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id) begin
                errors++;
                $display("FAIL idle_basic[%0d]: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         i, grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
            if (i == 2) begin
                checks++;
                if (grant_valid !== 1'b1 || grant_one_hot !== 4'b0010 ||
                    grant_id !== 2'd1) begin
                    errors++;
                    $display("FAIL first_grant: got v=%b oh=%b id=%0d want 1 0010 1",
                             grant_valid, grant_one_hot, grant_id);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ids [0:4];
        ids = '{0, 1, 2, 3, 0};
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, (i != 0), 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id || grant_valid !== 1'b1 ||
                grant_id !== 2'(ids[i])) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%b id=%0d want v=1 id=%0d",
                         i, grant_valid, grant_id, ids[i]);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        logic [3:0] rq [0:4];
        rq = '{4'b1011, 4'b0001, 4'b1111, 4'b0000, 4'b1000};
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b0100, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b0, rq[i], 1'b0, 1'b0);
            else       drive(1'b0, 4'b0000, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id ||
                grant_one_hot !== ((i < 5) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL hold[%0d]: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         i, grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b0100, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0101, (i == 1), 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id ||
                grant_id !== ((i == 0) ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL wrap[%0d]: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         i, grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
        end
    endtask

    task automatic test_reset_granted();
        exp_t e;
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b1111, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b1111, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive((i == 0), 4'b1111, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id ||
                grant_one_hot !== ((i == 0) ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL reset_granted[%0d]: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         i, grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
        end
    endtask

`ifdef RR_GRANT_LOCK_EN
    task automatic test_lock();
        exp_t e;
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b0001, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 4'b0011, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0011, 1'b1, (i < 3));
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id ||
                grant_id !== ((i < 3) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL lock[%0d]: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         i, grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
        end
    endtask
`endif

    task automatic test_random();
        exp_t e;
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 40) == 0), 4'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = sb.pop_front();
            checks++;
            if (grant_valid !== e.v || grant_one_hot !== e.oh ||
                grant_id !== e.id) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b oh=%b id=%0d want v=%b oh=%b id=%0d",
                         i, grant_valid, grant_one_hot, grant_id, e.v, e.oh, e.id);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        request   = 4'b0000;
        grant_ack = 1'b0;
        lock_i    = 1'b0;
        test_reset();
        test_idle_basic();
        test_back_to_back();
        test_hold();
        test_wrap();
        test_reset_granted();
`ifdef RR_GRANT_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
